instr_fetch_unit: RTL and testbench

- Fetch controller that sequences the 256-byte, word-addressed instruction memory.
- Owns the program counter, drives the memory address, and registers each returned word into a one-entry fetch buffer toward decode using a valid/ready handshake.
- Handles branch redirects and stalls.
- Stops fetching when the program-end sentinel word is read.

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 84 ++++++++
 tb/tb_instr_fetch_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory port, redirect/stall controls, and the decode buffer handshake.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid, halted,
    input  imem_data, stall, br_taken, br_target, instr_ready
  );

  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid, halted,
    output imem_data, stall, br_taken, br_target, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch controller: owns the PC, one-cycle fetch into a single-entry buffer, redirects, stall, halt on sentinel.
// Address-to-instr latency is one cycle; the buffer holds while valid and not accepted, or under stall.
module instr_fetch_unit #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_WORD = 32'h11111111
) (
  input  logic                       clk,
  input  logic                       reset,
  instr_fetch_unit_if.master         io_fetch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_valid;
  logic              r_halted;

  logic              w_load;
  logic [ADDR_W-1:0] w_target;

  assign w_target = {io_fetch.br_target[ADDR_W-1:2], 2'b00};
  assign w_load   = (r_state == RUN) && !io_fetch.stall &&
                    (!r_valid || io_fetch.instr_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= RUN;
          if (io_fetch.br_taken) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
          end
        end
        RUN: begin
          // Redirect outranks stall, load and sentinel detection.
          if (io_fetch.br_taken) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
          end else if (w_load) begin
            if (io_fetch.imem_data == HALT_WORD) begin
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= HALT;
            end else begin
              r_instr    <= io_fetch.imem_data;
              r_instr_pc <= r_pc;
              r_pc       <= r_pc + ADDR_W'(4);
              r_valid    <= 1'b1;
            end
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_fetch.imem_addr   = r_pc;
  assign io_fetch.instr       = r_instr;
  assign io_fetch.instr_pc    = r_instr_pc;
  assign io_fetch.instr_valid = r_valid;
  assign io_fetch.halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small combinational instruction memory.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [0:63];

  instr_fetch_unit_if #(.ADDR_W(8)) u_if ();

  instr_fetch_unit #(
    .ADDR_W   (8),
    .RESET_PC (8'h00),
    .HALT_WORD(32'h11111111)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .io_fetch(u_if)
  );

  assign u_if.imem_data = mem[u_if.imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {16'hC0DE, a, 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_buf(input string tag, input logic vld, input logic [7:0] pc, input logic [7:0] addr);
    chk({tag, ".valid"}, {31'd0, u_if.instr_valid}, {31'd0, vld});
    chk({tag, ".addr"}, {24'd0, u_if.imem_addr}, {24'd0, addr});
    if (vld) begin
      chk({tag, ".pc"}, {24'd0, u_if.instr_pc}, {24'd0, pc});
      chk({tag, ".instr"}, u_if.instr, pat(pc));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 64; i++) mem[i] = pat(8'(i * 4));
    mem[8'h78 >> 2] = 32'h11111111;

    reset            = 1'b1;
    u_if.stall       = 1'b0;
    u_if.br_taken    = 1'b0;
    u_if.br_target   = 8'h00;
    u_if.instr_ready = 1'b1;
    step();
    step();
    chk("rst.valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("rst.halted", {31'd0, u_if.halted}, 32'd0);
    chk("rst.addr", {24'd0, u_if.imem_addr}, 32'h00);
    chk("rst.instr", u_if.instr, 32'd0);
    chk("rst.ipc", {24'd0, u_if.instr_pc}, 32'd0);
    reset = 1'b0;

    // Sequential fetch: IDLE edge first, then one word per edge.
    step();
    chk_buf("idle", 1'b0, 8'h00, 8'h00);
    step();
    chk_buf("seq0", 1'b1, 8'h00, 8'h04);
    step();
    chk_buf("seq1", 1'b1, 8'h04, 8'h08);
    step();
    chk_buf("seq2", 1'b1, 8'h08, 8'h0C);

    u_if.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_buf("bp_hold", 1'b1, 8'h08, 8'h0C);
    end
    u_if.instr_ready = 1'b1;
    step();
    chk_buf("bp_rel0", 1'b1, 8'h0C, 8'h10);
    step();
    chk_buf("bp_rel1", 1'b1, 8'h10, 8'h14);

    u_if.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk_buf("stall_hold", 1'b1, 8'h10, 8'h14);
    end
    u_if.br_taken  = 1'b1;
    u_if.br_target = 8'h5E;
    step();
    chk_buf("br_flush", 1'b0, 8'h00, 8'h5C);
    u_if.br_taken = 1'b0;
    u_if.stall    = 1'b0;
    step();
    chk_buf("br_first", 1'b1, 8'h5C, 8'h60);

    for (int k = 0; k < 6; k++) begin
      step();
      chk_buf("run_to_halt", 1'b1, 8'(8'h60 + 4 * k), 8'(8'h64 + 4 * k));
    end
    step();
    chk("halt.halted", {31'd0, u_if.halted}, 32'd1);
    chk("halt.valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("halt.addr", {24'd0, u_if.imem_addr}, 32'h78);
    chk("halt.instr", u_if.instr, pat(8'h74));
    chk("halt.ipc", {24'd0, u_if.instr_pc}, 32'h74);
    u_if.br_taken  = 1'b1;
    u_if.br_target = 8'h40;
    step();
    u_if.br_taken = 1'b0;
    chk("halt_br.halted", {31'd0, u_if.halted}, 32'd1);
    chk_buf("halt_br", 1'b0, 8'h00, 8'h78);
    step();
    chk_buf("halt_after", 1'b0, 8'h00, 8'h78);

    // Asynchronous reset out of HALT, observed mid-cycle.
    #3;
    reset = 1'b1;
    #1;
    chk("arst1.halted", {31'd0, u_if.halted}, 32'd0);
    chk("arst1.valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("arst1.addr", {24'd0, u_if.imem_addr}, 32'h00);
    step();
    reset = 1'b0;
    step();
    u_if.br_taken  = 1'b1;
    u_if.br_target = 8'h79;
    step();
    chk_buf("to_sentinel", 1'b0, 8'h00, 8'h78);
    u_if.br_target = 8'h24;
    step();
    u_if.br_taken = 1'b0;
    chk("squash.halted", {31'd0, u_if.halted}, 32'd0);
    chk_buf("squash", 1'b0, 8'h00, 8'h24);
    step();
    chk_buf("squash_run", 1'b1, 8'h24, 8'h28);

    u_if.br_taken  = 1'b1;
    u_if.br_target = 8'hFC;
    step();
    u_if.br_taken = 1'b0;
    chk_buf("wrap_br", 1'b0, 8'h00, 8'hFC);
    step();
    chk_buf("wrap_fc", 1'b1, 8'hFC, 8'h00);
    step();
    chk_buf("wrap_00", 1'b1, 8'h00, 8'h04);

    #3;
    reset = 1'b1;
    #1;
    chk("arst2.valid", {31'd0, u_if.instr_valid}, 32'd0);
    chk("arst2.halted", {31'd0, u_if.halted}, 32'd0);
    chk("arst2.addr", {24'd0, u_if.imem_addr}, 32'h00);
    chk("arst2.instr", u_if.instr, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
